// File: rtl/aes_iter_ctrl.sv
// aes_iter_ctrl -- iterative AES-128 encryption controller.
//
// Runs one shared round datapath (subBytes, shiftRows, mixColumns,
// addRoundKey) over ten rounds. Round keys are expanded on the fly, one per
// round, from the previous round key.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. in_ready is high only in IDLE, so in_data and in_key are
// sampled on the accept edge alone. out_valid and out_data are registered
// and hold steady in DONE until out_ready is seen.
//
// Ports:
//   clk, rst              clock (rising edge), async active-high reset
//   in_valid / in_ready   plaintext+key handshake
//   in_data, in_key       128-bit plaintext and key; bits [127:120] = byte 0
//   out_valid / out_ready ciphertext handshake
//   out_data              128-bit ciphertext
//   busy                  high in ROUND and DONE
//   dbgState              FSM state (0 IDLE, 1 ROUND, 2 DONE)
//
// Build option: define AES_ITER_ZEROIZE_EN to clear st, rk and out_data on
// the DONE->IDLE handshake.
module aes_iter_ctrl (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_data,
   input  logic [127:0] in_key,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data,
   output logic         busy,
   output logic [1:0]   dbgState
);

   typedef enum logic [1:0] {IDLE = 2'd0, ROUND = 2'd1, DONE = 2'd2} stateT;

   // Forward S-box; element 0 is the most significant byte.
   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [127:0] subBytes(input logic [127:0] s);
      logic [127:0] o;
      for (int i = 0; i < 16; i++) o[8*i +: 8] = SBOX[s[8*i +: 8]];
      return o;
   endfunction

   // Byte b = row + 4*col sits at bits [127-8b -: 8]; row r rotates left by r.
   function automatic logic [127:0] shiftRows(input logic [127:0] s);
      logic [127:0] o;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[127 - 8*(r + 4*c) -: 8] = s[127 - 8*(r + 4*((c + r) % 4)) -: 8];
      return o;
   endfunction

   function automatic logic [7:0] xt(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [127:0] mixColumns(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   a0, a1, a2, a3;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127 - 32*c -: 8];
         a1 = s[119 - 32*c -: 8];
         a2 = s[111 - 32*c -: 8];
         a3 = s[103 - 32*c -: 8];
         o[127 - 32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
         o[119 - 32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
         o[111 - 32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
         o[103 - 32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
      end
      return o;
   endfunction

   // SubWord goes through the shared subBytes path; only the low word matters.
   function automatic logic [31:0] subWord(input logic [31:0] w);
      logic [127:0] t;
      t = subBytes({96'd0, w});
      return t[31:0];
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] r);
      case (r)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   stateT        fsm;
   logic [127:0] st, rk;
   logic [3:0]   rnd;

   logic [31:0]  w0n, w1n, w2n, w3n;
   logic [127:0] rkNext, srOut, roundOut, finalOut;

   always_comb begin
      w0n      = rk[127:96] ^ subWord({rk[23:0], rk[31:24]}) ^ {rcon(rnd), 24'd0};
      w1n      = rk[95:64] ^ w0n;
      w2n      = rk[63:32] ^ w1n;
      w3n      = rk[31:0]  ^ w2n;
      rkNext   = {w0n, w1n, w2n, w3n};
      srOut    = shiftRows(subBytes(st));
      roundOut = mixColumns(srOut) ^ rkNext;
      // Last round skips MixColumns but shares the subBytes/shiftRows result.
      finalOut = srOut ^ rkNext;
   end

   assign dbgState = fsm;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsm       <= IDLE;
         st        <= '0;
         rk        <= '0;
         rnd       <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_data  <= '0;
         busy      <= 1'b0;
      end else begin
         case (fsm)
            IDLE: begin
               if (in_valid && in_ready) begin
                  st       <= in_data ^ in_key;
                  rk       <= in_key;
                  rnd      <= 4'd1;
                  fsm      <= ROUND;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
               end
            end
            ROUND: begin
               rk <= rkNext;
               if (rnd == 4'd10) begin
                  st        <= finalOut;
                  out_data  <= finalOut;
                  out_valid <= 1'b1;
                  fsm       <= DONE;
               end else begin
                  st  <= roundOut;
                  rnd <= rnd + 4'd1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  fsm       <= IDLE;
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  in_ready  <= 1'b1;
`ifdef AES_ITER_ZEROIZE_EN
                  st        <= '0;
                  rk        <= '0;
                  out_data  <= '0;
`endif
               end
            end
            default: begin
               fsm      <= IDLE;
               in_ready <= 1'b1;
               busy     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_aes_iter_ctrl.sv
// Testbench for aes_iter_ctrl: FIPS-197 known-answer vectors, backpressure,
// busy-time input, asynchronous reset and the zeroize option.
module tb_aes_iter_ctrl;

   logic         clk;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_data;
   logic [127:0] in_key;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_data;
   logic         busy;
   logic [1:0]   dbgState;

   int checks = 0;
   int failures = 0;
   logic [127:0] exp_q[$];

   localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] PT_S  = 128'h6bc1bee22e409f96e93d7e117393172a;
   localparam logic [127:0] CT_S  = 128'h3ad77bb40d7a3660a89ecaf32466ef97;

   aes_iter_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_key    (in_key),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy),
      .dbgState  (dbgState)
   );

   // Clock / watchdog
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge of the first ROUND cycle.
   task automatic sendTxn(input string tag, input logic [127:0] pt, input logic [127:0] key,
                          input logic [127:0] exp);
      int n = 0;
      in_valid = 1'b1;
      in_data  = pt;
      in_key   = key;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_accept_ready"}, in_ready, 1'b1);
      exp_q.push_back(exp);
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = {$urandom, $urandom, $urandom, $urandom};
      in_key   = {$urandom, $urandom, $urandom, $urandom};
   endtask

   // Latency counts the accept cycle as 0; entry at cycle 1 negedge.
   task automatic waitOutput(input string tag, input bit checkLat);
      int lat = 1;
      logic [127:0] exp;
      while (!out_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      check({tag, "_out_valid"}, out_valid, 1'b1);
      if (checkLat) check({tag, "_latency"}, lat, 11);
      exp = '0;
      if (exp_q.size() > 0) exp = exp_q.pop_front();
      else check({tag, "_queue_nonempty"}, exp_q.size(), 1);
      check({tag, "_out_data"}, out_data, exp);
   endtask

   initial begin
      logic [127:0] discard;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      in_key    = '0;
      out_ready = 1'b0;

      // Reset values
      #2;
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_data", out_data, '0);
      check("rst_busy", busy, 1'b0);
      check("rst_state", dbgState, 2'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // FIPS-197 App. B with out_ready held high
      out_ready = 1'b1;
      sendTxn("appb", PT_B, KEY_B, CT_B);
      check("appb_busy", busy, 1'b1);
      waitOutput("appb", 1'b1);
      @(negedge clk);
      check("appb_after_in_ready", in_ready, 1'b1);
      check("appb_after_out_valid", out_valid, 1'b0);
      check("appb_after_busy", busy, 1'b0);
`ifdef AES_ITER_ZEROIZE_EN
      check("zeroize_out_data", out_data, '0);
`else
      check("retain_out_data", out_data, CT_B);
`endif

      // FIPS-197 C.1; out_ready early has no effect, then backpressure
      out_ready = 1'b0;
      sendTxn("c1", PT_C, KEY_C, CT_C);
      out_ready = 1'b1;
      repeat (5) begin
         @(negedge clk);
         check("c1_early_ready_no_valid", out_valid, 1'b0);
      end
      out_ready = 1'b0;
      waitOutput("c1", 1'b0);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("bp_out_valid", out_valid, 1'b1);
         check("bp_out_data", out_data, CT_C);
         check("bp_in_ready", in_ready, 1'b0);
      end
      check("bp_state_done", dbgState, 2'd2);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("bp_release_in_ready", in_ready, 1'b1);
      check("bp_release_out_valid", out_valid, 1'b0);

      // Busy-time input: new vector offered during ROUND is held off
      out_ready = 1'b1;
      sendTxn("busy1", PT_S, KEY_B, CT_S);
      in_valid = 1'b1;
      in_data  = PT_C;
      repeat ($urandom_range(3, 6)) begin
         in_key = {$urandom, $urandom, $urandom, $urandom};
         @(negedge clk);
         check("busy_in_ready_low", in_ready, 1'b0);
      end
      in_key = KEY_C;
      waitOutput("busy1", 1'b0);
      @(negedge clk);
      check("busy2_in_ready_idle", in_ready, 1'b1);
      exp_q.push_back(CT_C);
      @(negedge clk);
      in_valid = 1'b0;
      check("busy2_accepted", busy, 1'b1);
      waitOutput("busy2", 1'b1);
      @(negedge clk);

      // Async reset during round 5
      sendTxn("rstmid", PT_B, KEY_B, CT_B);
      repeat (4) @(negedge clk);
      check("rstmid_busy_before", busy, 1'b1);
      #2 rst = 1'b1;
      #1;
      check("rstmid_out_valid", out_valid, 1'b0);
      check("rstmid_in_ready", in_ready, 1'b1);
      check("rstmid_out_data", out_data, '0);
      check("rstmid_busy", busy, 1'b0);
      discard = exp_q.pop_back();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      sendTxn("appb2", PT_B, KEY_B, CT_B);
      waitOutput("appb2", 1'b1);
      @(negedge clk);
      check("appb2_in_ready", in_ready, 1'b1);

      check("queue_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
